inst_prefetch: RTL and testbench
================================

INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 SHALL have parameter: DEPTH, 4, instruction queue entries (power of two, >=2).
REQ-002 SHALL have parameter: PC_STEP, 4, byte increment of sequential fetch PC.
REQ-003 SHALL have ports: clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: iresp  in  ibus_resp_t  bus response (addr_ok, data_ok, data).
REQ-006 SHALL have ports: ireq  out  ibus_req_t  bus request (valid, addr), registered.
REQ-007 SHALL have ports: redirect  in  1  flush and restart fetch.
REQ-008 SHALL have ports: redirect_pc  in  addr_t  restart address.
REQ-009 SHALL have ports: out_valid  out  1  head entry available.
REQ-010 SHALL have ports: out_ready  in  1  consumer accepts head.
REQ-011 SHALL have ports: out_inst  out  inst_t  head instruction.
REQ-012 SHALL have ports: out_pc  out  addr_t  head instruction address.
REQ-013 SHALL have ports: count  out  $clog2(DEPTH+1)  valid queue entries.
REQ-014 SHALL have ports: busy  out  1  bus transaction outstanding (state != IDLE).

Function
REQ-015 SHALL keep fetch_pc (next address to request) and a circular queue of DEPTH {inst, pc} entries with head/tail pointers wrapping mod DEPTH.
REQ-016 SHALL implement FSM IDLE, REQ (ireq.valid=1), WAIT (valid=0, awaiting data_ok), DROP (stale transaction, response discarded).
REQ-017 SHALL, IDLE: when count < DEPTH and redirect=0, register ireq.valid=1, ireq.addr=fetch_pc, go REQ (request visible next cycle).
REQ-018 SHALL hold ireq.valid and ireq.addr stable in REQ until addr_ok; addr_ok without data_ok -> valid=0, go WAIT.
REQ-019 SHALL, on data_ok in REQ or WAIT (incl. addr_ok+data_ok same cycle): enqueue {iresp.data, ireq.addr}, fetch_pc += PC_STEP, valid=0, go IDLE; entry shows out_valid next cycle.
REQ-020 SHALL allow at most one outstanding transaction; issue only at count < DEPTH guarantees no overflow.
REQ-021 SHALL drive out_valid = (count != 0), out_inst/out_pc from head entry, combinationally.
REQ-022 SHALL pop head when out_valid && out_ready; push+pop same cycle leaves count unchanged.
REQ-023 SHALL, on redirect: count=0, head=tail, fetch_pc=redirect_pc; a pop in the same cycle is void.
REQ-024 SHALL, on redirect in REQ or WAIT, go DROP; a data_ok in that same cycle is discarded and goes IDLE instead.
REQ-025 SHALL, in DROP: keep ireq.valid until addr_ok, then valid=0; on data_ok discard data, go IDLE; redirect in DROP updates fetch_pc only.
REQ-026 SHALL not issue in the cycle redirect is high; next issue uses redirect_pc.
REQ-027 SHALL ignore addr_ok/data_ok while IDLE.
REQ-028 SHALL wrap fetch_pc modulo 2^width(addr_t).

Reset
REQ-029 SHALL on rst: state=IDLE, ireq.valid=0, ireq.addr=PCINIT, fetch_pc=PCINIT, head=tail=0, count=0, out_valid=0, busy=0.
REQ-030 SHALL treat rst mid-transaction as abandoning it; later stray data_ok is ignored (REQ-027).
REQ-031 SHALL have out_inst/out_pc reflect entry 0 contents (zero after reset) when count=0.

Verification
REQ-032 SHALL cover: reset, out_ready=1, bus answers addr_ok+data_ok one cycle after each valid -> out_pc PCINIT, PCINIT+4, PCINIT+8 in order with matching data.
REQ-033 SHALL cover: DEPTH=4, out_ready=0 -> count reaches 4, ireq.valid stays 0; one pop -> exactly one new request at next sequential PC.
REQ-034 SHALL cover: redirect to 0x8000_1000 while WAIT, data_ok 3 cycles later with 0xDEAD_BEEF -> count=0, data discarded, next request addr 0x8000_1000.
REQ-035 SHALL cover: redirect while REQ without addr_ok -> ireq.valid held until addr_ok, response discarded, then request at redirect_pc.
REQ-036 SHALL cover: count=2, push and pop same cycle -> count=2, order preserved across tail wrap from 3 to 0.
REQ-037 SHALL cover: rst asserted in WAIT, data_ok one cycle after deassert -> ignored, count=0, first request addr PCINIT.

Source files
------------

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: sequential fetch over a single-outstanding bus into a small
// circular queue, with redirect flushing the queue and discarding an in-flight response.
package inst_prefetch_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_t;

  localparam addr_t PCINIT = 32'h8000_0000;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    inst_t data;
  } ibus_resp_t;
endpackage

// state  | meaning
// S_IDLE | no bus transaction; issues when the queue has room and no redirect
// S_REQ  | request presented (ireq.valid=1), waiting for addr_ok
// S_WAIT | address accepted, waiting for data_ok
// S_DROP | transaction made stale by a redirect; response is discarded
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PC_STEP = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  ibus_resp_t                 iresp,
  output ibus_req_t                  ireq,
  input  logic                       redirect,
  input  addr_t                      redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output inst_t                      out_inst,
  output addr_t                      out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam addr_t STEP = addr_t'(PC_STEP);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t        state_q, state_d;
  ibus_req_t     req_q, req_d;
  addr_t         fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  inst_t         inst_mem_q [DEPTH];
  inst_t         inst_mem_d [DEPTH];
  addr_t         pc_mem_q   [DEPTH];
  addr_t         pc_mem_d   [DEPTH];
  logic          push, pop;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    push       = 1'b0;
    pop        = (count_q != '0) && out_ready && !redirect;

    case (state_q)
      S_IDLE: begin
        if (count_q < FULL && !redirect) begin
          req_d.valid = 1'b1;
          req_d.addr  = fetch_pc_q;
          state_d     = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        if (redirect) begin
          // A response landing in the redirect cycle is already stale.
          if (iresp.data_ok) begin
            req_d.valid = 1'b0;
            state_d     = S_IDLE;
          end else begin
            if (iresp.addr_ok) req_d.valid = 1'b0;
            state_d = S_DROP;
          end
        end else if (iresp.data_ok) begin
          push        = 1'b1;
          fetch_pc_d  = fetch_pc_q + STEP;
          req_d.valid = 1'b0;
          state_d     = S_IDLE;
        end else if (iresp.addr_ok) begin
          req_d.valid = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_DROP: begin
        if (iresp.addr_ok) req_d.valid = 1'b0;
        if (iresp.data_ok) begin
          req_d.valid = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase

    if (push) begin
      inst_mem_d[tail_q] = iresp.data;
      pc_mem_d[tail_q]   = req_q.addr;
      tail_d             = tail_q + PW'(1);
    end

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      head_d     = tail_q;
      count_d    = '0;
    end else begin
      if (pop) head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= '{valid: 1'b0, addr: PCINIT};
      fetch_pc_q <= PCINIT;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inst_mem_q <= '{default: '0};
      pc_mem_q   <= '{default: '0};
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

  assign ireq      = req_q;
  assign out_valid = (count_q != '0);
  assign out_inst  = inst_mem_q[head_q];
  assign out_pc    = pc_mem_q[head_q];
  assign count     = count_q;
  assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: directed scenarios plus random traffic, with popped entries
// checked against an expected sequential-PC stream kept in a scoreboard queue.
module tb_inst_prefetch;
  import inst_prefetch_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  ibus_resp_t iresp;
  ibus_req_t  ireq;
  logic       redirect = 1'b0;
  addr_t      redirect_pc = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  inst_t      out_inst;
  addr_t      out_pc;
  logic [2:0] count;
  logic       busy;

  inst_prefetch #(.DEPTH(4), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .iresp(iresp), .ireq(ireq),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_pops = 0;

  // bus_mode: 0 = manual (man_*), 1 = random latency, 2 = answer one cycle after valid
  int    bus_mode = 0;
  logic  man_addr_ok = 1'b0;
  logic  man_data_ok = 1'b0;
  inst_t man_data = '0;

  addr_t exp_q[$];
  addr_t exp_last;

  function automatic inst_t f_data(addr_t a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream restarts at pc and continues sequentially.
  task automatic sb_restart(addr_t pc);
    exp_q.delete();
    exp_last = pc;
    exp_q.push_back(pc);
    for (int i = 0; i < 7; i++) begin
      exp_last = exp_last + 32'd4;
      exp_q.push_back(exp_last);
    end
  endtask

  // Bus responder
  int    phase = 0;
  int    addr_cnt = 0;
  int    data_cnt = 0;
  addr_t cap_addr = '0;

  always @(posedge clk) begin
    #2;
    iresp = '0;
    if (bus_mode == 0) begin
      phase         = 0;
      iresp.addr_ok = man_addr_ok;
      iresp.data_ok = man_data_ok;
      iresp.data    = man_data;
    end else begin
      if (phase == 0 && ireq.valid) begin
        phase    = 1;
        addr_cnt = (bus_mode == 2) ? 0 : int'($urandom_range(0, 2));
      end
      if (phase == 1) begin
        if (addr_cnt == 0) begin
          iresp.addr_ok = 1'b1;
          cap_addr      = ireq.addr;
          data_cnt      = (bus_mode == 2) ? 0 : int'($urandom_range(0, 3));
          if (data_cnt == 0) begin
            iresp.data_ok = 1'b1;
            iresp.data    = f_data(cap_addr);
            phase         = 0;
          end else begin
            phase = 2;
          end
        end else begin
          addr_cnt--;
        end
      end else if (phase == 2) begin
        data_cnt--;
        if (data_cnt == 0) begin
          iresp.data_ok = 1'b1;
          iresp.data    = f_data(cap_addr);
          phase         = 0;
        end
      end
    end
  end

  // Monitor: every accepted head entry is compared with the scoreboard front.
  always @(negedge clk) begin
    addr_t e;
    if (!rst && out_valid && out_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", out_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", out_pc, e);
        chk("pop_inst", out_inst, f_data(e));
        exp_last = exp_last + 32'd4;
        exp_q.push_back(exp_last);
      end
      n_pops++;
    end
  end

  task automatic do_reset();
    bus_mode    = 0;
    man_addr_ok = 1'b0;
    man_data_ok = 1'b0;
    redirect    = 1'b0;
    out_ready   = 1'b0;
    rst         = 1'b1;
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ireq_valid", 32'(ireq.valid), 32'd0);
    chk("rst_ireq_addr", ireq.addr, PCINIT);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    rst    = 1'b0;
    n_pops = 0;
    sb_restart(PCINIT);
  endtask

  task automatic wait_valid(string nm, int maxc);
    for (int i = 0; i < maxc && !ireq.valid; i++) tick();
    chk(nm, 32'(ireq.valid), 32'd1);
  endtask

  task automatic wait_pops(string nm, int target, int maxc);
    for (int i = 0; i < maxc && n_pops < target; i++) tick();
    chk(nm, 32'(n_pops >= target), 32'd1);
  endtask

  task automatic fetch_one(logic with_pop);
    wait_valid("fetch_valid", 10);
    man_addr_ok = 1'b1;
    man_data_ok = 1'b1;
    man_data    = f_data(ireq.addr);
    out_ready   = with_pop;
    tick();
    man_addr_ok = 1'b0;
    man_data_ok = 1'b0;
    out_ready   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_req;
    addr_t first_addr;
    logic prev_valid;
    iresp = '0;

    // Sequential fetch with an immediate-answer bus
    do_reset();
    bus_mode  = 2;
    out_ready = 1'b1;
    wait_pops("seq_pops", 3, 40);

    // Queue fills to DEPTH, then one pop allows exactly one new fetch
    do_reset();
    bus_mode = 2;
    for (int i = 0; i < 40 && count != 3'd4; i++) tick();
    chk("full_count", 32'(count), 32'd4);
    n_req = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ireq.valid) n_req++;
    end
    chk("full_no_req", 32'(n_req), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready  = 1'b0;
    n_req      = 0;
    first_addr = '0;
    prev_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ireq.valid && !prev_valid) begin
        n_req++;
        if (n_req == 1) first_addr = ireq.addr;
      end
      prev_valid = ireq.valid;
      tick();
    end
    chk("refill_req_count", 32'(n_req), 32'd1);
    chk("refill_req_addr", first_addr, PCINIT + 32'd16);
    chk("refill_count", 32'(count), 32'd4);
    chk("refill_pops", 32'(n_pops), 32'd1);

    // Redirect while waiting for data
    do_reset();
    wait_valid("w_valid", 10);
    man_addr_ok = 1'b1;
    tick();
    man_addr_ok = 1'b0;
    chk("w_busy", 32'(busy), 32'd1);
    chk("w_valid_low", 32'(ireq.valid), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h8000_1000;
    sb_restart(32'h8000_1000);
    tick();
    redirect = 1'b0;
    tick();
    tick();
    man_data_ok = 1'b1;
    man_data    = 32'hDEAD_BEEF;
    tick();
    man_data_ok = 1'b0;
    chk("w_count_after_drop", 32'(count), 32'd0);
    wait_valid("w_new_valid", 5);
    chk("w_new_addr", ireq.addr, 32'h8000_1000);
    chk("w_count", 32'(count), 32'd0);
    bus_mode  = 1;
    out_ready = 1'b1;
    wait_pops("w_pops", 2, 60);

    // Redirect while the request is still presented
    do_reset();
    wait_valid("r_valid", 10);
    chk("r_addr0", ireq.addr, PCINIT);
    redirect    = 1'b1;
    redirect_pc = 32'h4000_0000;
    sb_restart(32'h4000_0000);
    tick();
    redirect = 1'b0;
    chk("r_hold_valid", 32'(ireq.valid), 32'd1);
    chk("r_hold_addr", ireq.addr, PCINIT);
    tick();
    chk("r_hold_valid2", 32'(ireq.valid), 32'd1);
    man_addr_ok = 1'b1;
    tick();
    man_addr_ok = 1'b0;
    chk("r_valid_dropped", 32'(ireq.valid), 32'd0);
    chk("r_busy", 32'(busy), 32'd1);
    man_data_ok = 1'b1;
    man_data    = f_data(PCINIT);
    tick();
    man_data_ok = 1'b0;
    chk("r_count", 32'(count), 32'd0);
    wait_valid("r_new_valid", 5);
    chk("r_new_addr", ireq.addr, 32'h4000_0000);
    bus_mode  = 1;
    out_ready = 1'b1;
    wait_pops("r_pops", 2, 60);

    // Push and pop in one cycle at count 2, across the tail wrap
    do_reset();
    fetch_one(1'b0);
    fetch_one(1'b0);
    fetch_one(1'b0);
    chk("pp_count3", 32'(count), 32'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pp_count2", 32'(count), 32'd2);
    fetch_one(1'b1);
    chk("pp_wrap_count", 32'(count), 32'd2);
    fetch_one(1'b1);
    chk("pp_after_wrap_count", 32'(count), 32'd2);
    bus_mode  = 1;
    out_ready = 1'b1;
    wait_pops("pp_drain", 7, 80);

    // Reset in the middle of a transaction, stray data_ok afterwards
    do_reset();
    wait_valid("x_valid", 10);
    man_addr_ok = 1'b1;
    tick();
    man_addr_ok = 1'b0;
    chk("x_busy_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("x_busy_rst", 32'(busy), 32'd0);
    rst         = 1'b0;
    n_pops      = 0;
    sb_restart(PCINIT);
    man_data_ok = 1'b1;
    man_data    = 32'hDEAD_BEEF;
    tick();
    man_data_ok = 1'b0;
    chk("x_count", 32'(count), 32'd0);
    chk("x_req_valid", 32'(ireq.valid), 32'd1);
    chk("x_req_addr", ireq.addr, PCINIT);
    bus_mode  = 1;
    out_ready = 1'b1;
    wait_pops("x_pops", 2, 60);

    // Random traffic with occasional redirects, including a PC wrap
    do_reset();
    bus_mode = 1;
    for (int c = 0; c < 1500; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (c == 700) begin
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        sb_restart(32'hFFFF_FFF8);
      end else if ($urandom_range(0, 39) == 0) begin
        redirect    = 1'b1;
        redirect_pc = $urandom & 32'hFFFF_FFFC;
        sb_restart(redirect_pc);
      end else begin
        redirect = 1'b0;
      end
      tick();
    end
    redirect = 1'b0;
    chk("rand_progress", 32'(n_pops > 100), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
